hub75_bcm_scan: RTL and testbench

HUB75_BCM_SCAN -- requirements
Module: hub75_bcm_scan

---
 rtl/hub75_pkg.sv | 22 ++
 rtl/hub75_row_shifter.sv | 78 +++++++
 rtl/hub75_bcm_scan.sv | 164 ++++++++++++++++
 tb/tb_hub75_bcm_scan.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 bit-plane scanner: FSM states, colour bit lanes,
// and the per-plane display length helper.
package hub75_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_SHOW  = 2'd3
    } scan_state_t;

    // Lane positions inside the 3-bit {b,g,r} panel data buses.
    localparam int RGB_R = 0;
    localparam int RGB_G = 1;
    localparam int RGB_B = 2;

    // Binary-weighted on-time of one bit plane, in clk cycles.
    function automatic int show_cycles(input int on_base, input int plane_idx);
        return on_base << plane_idx;
    endfunction

endpackage

// File: rtl/hub75_row_shifter.sv
// Shifts one row of bit-plane data into the panel: walks addrx, captures rgb, pulses sclk.
// Latency: 2*COLS+2 cycles from start to the last cycle (done); rgb trails addrx by 2 cycles.
// No backpressure: pixel source must answer one clk after addrx changes.
module hub75_row_shifter
    import hub75_pkg::*;
#(
    parameter int COLS  = 64,
    parameter int DEPTH = 8,
    parameter int PW    = 3,
    localparam int XW   = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PW-1:0]    plane,
    input  logic [DEPTH-1:0] r0,
    input  logic [DEPTH-1:0] g0,
    input  logic [DEPTH-1:0] b0,
    input  logic [DEPTH-1:0] r1,
    input  logic [DEPTH-1:0] g1,
    input  logic [DEPTH-1:0] b1,
    output logic [XW-1:0]    addrx,
    output logic             sclk,
    output logic [2:0]       rgb0,
    output logic [2:0]       rgb1,
    output logic             first,
    output logic             done
);

    localparam int KW = $clog2(2 * COLS + 2);
    localparam logic [KW-1:0] K_LAST     = KW'(2 * COLS + 1);
    localparam logic [KW-1:0] K_CAP_END  = KW'(2 * COLS);
    localparam logic [KW-1:0] K_SCLK_MIN = KW'(3);

    logic          busy;
    logic [KW-1:0] k;
    logic          capture;

    // Odd k (=2x+1) is the cycle the source presents pixel x; capture makes it visible from 2x+2.
    assign capture = busy && k[0] && (k < K_CAP_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            k    <= '0;
        end else if (start) begin
            busy <= 1'b1;
            k    <= '0;
        end else if (busy) begin
            if (k == K_LAST) begin
                busy <= 1'b0;
            end else begin
                k <= k + KW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb0 <= '0;
            rgb1 <= '0;
        end else if (capture) begin
            rgb0[RGB_R] <= r0[plane];
            rgb0[RGB_G] <= g0[plane];
            rgb0[RGB_B] <= b0[plane];
            rgb1[RGB_R] <= r1[plane];
            rgb1[RGB_G] <= g1[plane];
            rgb1[RGB_B] <= b1[plane];
        end
    end

    // Column walks at half the cycle rate; sclk rises one cycle after each capture.
    assign addrx = k[XW:1];
    assign sclk  = busy && k[0] && (k >= K_SCLK_MIN);
    assign first = busy && (k == '0);
    assign done  = busy && (k == K_LAST);

endmodule

// File: rtl/hub75_bcm_scan.sv
// HUB75 panel scanner with binary-coded modulation: per row, per plane SHIFT -> LATCH -> SHOW.
// Latency: one plane period is 2*COLS+3+(ON_BASE<<plane) cycles; enable sampled in IDLE and at SHOW end.
// No backpressure: a started plane period always runs to completion.
module hub75_bcm_scan
    import hub75_pkg::*;
#(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 5,
    parameter int DEPTH    = 8,
    parameter int ON_BASE  = 2,
    localparam int XW      = $clog2(COLS),
    localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [DEPTH-1:0]    r0,
    input  logic [DEPTH-1:0]    g0,
    input  logic [DEPTH-1:0]    b0,
    input  logic [DEPTH-1:0]    r1,
    input  logic [DEPTH-1:0]    g1,
    input  logic [DEPTH-1:0]    b1,
    output logic [XW-1:0]       addrx,
    output logic [ROW_BITS-1:0] addry,
    output logic [2:0]          rgb0,
    output logic [2:0]          rgb1,
    output logic                sclk,
    output logic                latch,
    output logic                blank,
    output logic [PW-1:0]       plane,
    output logic                frame_start
);

    localparam int SHOW_MAX = ON_BASE << (DEPTH - 1);
    localparam int CW       = $clog2(SHOW_MAX + 1);

    scan_state_t         state;
    scan_state_t         next_state;
    logic [ROW_BITS-1:0] row;
    logic [ROW_BITS-1:0] row_adv;
    logic [PW-1:0]       plane_adv;
    logic                plane_last;
    logic [CW-1:0]       show_cnt;
    logic [CW-1:0]       show_load;
    logic                show_last;
    logic                shift_start;
    logic                shift_first;
    logic                shift_done;

    always_comb begin
        plane_last = (plane == PW'(DEPTH - 1));
        plane_adv  = plane_last ? '0 : plane + PW'(1);
        row_adv    = plane_last ? row + ROW_BITS'(1) : row;
        show_load  = CW'(show_cycles(ON_BASE, int'(plane)) - 1);
        show_last  = (show_cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        shift_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    next_state  = ST_SHIFT;
                    shift_start = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    next_state = ST_LATCH;
                end
            end
            ST_LATCH: begin
                next_state = ST_SHOW;
            end
            ST_SHOW: begin
                if (show_last) begin
                    if (enable) begin
                        next_state  = ST_SHIFT;
                        shift_start = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Row/plane advance at SHOW end; addry only follows on SHIFT entry so it never moves while lit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row      <= '0;
            plane    <= '0;
            addry    <= '0;
            show_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        row   <= '0;
                        plane <= '0;
                        addry <= '0;
                    end
                end
                ST_LATCH: begin
                    show_cnt <= show_load;
                end
                ST_SHOW: begin
                    if (show_last) begin
                        row   <= row_adv;
                        plane <= plane_adv;
                        if (enable) begin
                            addry <= row_adv;
                        end
                    end else begin
                        show_cnt <= show_cnt - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    hub75_row_shifter #(
        .COLS  (COLS),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (shift_start),
        .plane (plane),
        .r0    (r0),
        .g0    (g0),
        .b0    (b0),
        .r1    (r1),
        .g1    (g1),
        .b1    (b1),
        .addrx (addrx),
        .sclk  (sclk),
        .rgb0  (rgb0),
        .rgb1  (rgb1),
        .first (shift_first),
        .done  (shift_done)
    );

    // Decoded from registers only, so an async reset clears them without a clock edge.
    assign blank       = (state != ST_SHOW);
    assign latch       = (state == ST_LATCH);
    assign frame_start = (state == ST_SHIFT) && shift_first && (row == '0) && (plane == '0);

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Bench for hub75_bcm_scan: per-cycle comparison against a plane-period timing model,
// plus literal checks of the first frame and reset behaviour.
module tb_hub75_bcm_scan;

    localparam int C   = 4;
    localparam int RB  = 1;
    localparam int D   = 2;
    localparam int OB  = 2;
    localparam int TSH = 2 * C + 2;
    localparam int NLOG = 120;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] r0, g0, b0, r1, g1, b1;
    logic [1:0] addrx;
    logic [0:0] addry;
    logic [2:0] rgb0, rgb1;
    logic       sclk, latch, blank;
    logic [0:0] plane;
    logic       frame_start;

    // Pixel memories, packed {b[1:0], g[1:0], r[1:0]}, indexed [row][col].
    logic [5:0] p0 [2][4];
    logic [5:0] p1 [2][4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hub75_bcm_scan #(
        .COLS     (C),
        .ROW_BITS (RB),
        .DEPTH    (D),
        .ON_BASE  (OB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .r0          (r0),
        .g0          (g0),
        .b0          (b0),
        .r1          (r1),
        .g1          (g1),
        .b1          (b1),
        .addrx       (addrx),
        .addry       (addry),
        .rgb0        (rgb0),
        .rgb1        (rgb1),
        .sclk        (sclk),
        .latch       (latch),
        .blank       (blank),
        .plane       (plane),
        .frame_start (frame_start)
    );

    // Pixel source with one clk of read latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0 <= '0; g0 <= '0; b0 <= '0;
            r1 <= '0; g1 <= '0; b1 <= '0;
        end else begin
            r0 <= p0[addry][addrx][1:0];
            g0 <= p0[addry][addrx][3:2];
            b0 <= p0[addry][addrx][5:4];
            r1 <= p1[addry][addrx][1:0];
            g1 <= p1[addry][addrx][3:2];
            b1 <= p1[addry][addrx][5:4];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: position m_t inside the current plane period plus row/plane.
    bit m_act = 1'b0;
    int m_t = 0;
    int m_row = 0;
    int m_pl = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act <= 1'b0;
            m_t   <= 0;
            m_row <= 0;
            m_pl  <= 0;
        end else if (!m_act) begin
            if (enable) begin
                m_act <= 1'b1;
                m_t   <= 0;
                m_row <= 0;
                m_pl  <= 0;
            end
        end else if (m_t == TSH + (OB << m_pl)) begin
            if (m_pl == D - 1) begin
                m_pl  <= 0;
                m_row <= (m_row + 1) % (1 << RB);
            end else begin
                m_pl <= m_pl + 1;
            end
            if (enable) m_t <= 0;
            else        m_act <= 1'b0;
        end else begin
            m_t <= m_t + 1;
        end
    end

    int         cx;
    logic [2:0] e_rgb0, e_rgb1;

    always @(negedge clk) begin
        chk("blank", blank, !(m_act && m_t >= TSH + 1));
        chk("latch", latch, m_act && m_t == TSH);
        chk("sclk", sclk, m_act && m_t < TSH && m_t >= 3 && (m_t % 2) == 1);
        chk("frame_start", frame_start, m_act && m_t == 0 && m_row == 0 && m_pl == 0);
        if (m_act) begin
            chk("addry", addry, m_row);
            chk("plane", plane, m_pl);
            if (m_t < 2 * C) chk("addrx", addrx, m_t / 2);
            if (m_t >= 2 && m_t < TSH) begin
                cx = (m_t - 2) / 2;
                e_rgb0 = {p0[m_row][cx][4 + m_pl], p0[m_row][cx][2 + m_pl], p0[m_row][cx][m_pl]};
                e_rgb1 = {p1[m_row][cx][4 + m_pl], p1[m_row][cx][2 + m_pl], p1[m_row][cx][m_pl]};
                chk("rgb0", rgb0, e_rgb0);
                chk("rgb1", rgb1, e_rgb1);
            end
        end
    end

    logic lg_sclk [NLOG];
    logic lg_latch [NLOG];
    logic lg_blank [NLOG];
    logic lg_fs [NLOG];
    logic lg_r0b0 [NLOG];
    logic [0:0] lg_addry [NLOG];
    logic [0:0] lg_plane [NLOG];

    int sclk_p0 [4] = '{3, 5, 7, 9};
    int sclk_p1 [4] = '{16, 18, 20, 22};
    int bits_p0 [4] = '{0, 1, 0, 1};
    int bits_p1 [4] = '{0, 0, 1, 1};
    int sclk_lo [7] = '{0, 1, 2, 4, 6, 8, 10};

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_blank"}, blank, 1);
        chk({tag, "_latch"}, latch, 0);
        chk({tag, "_sclk"}, sclk, 0);
        chk({tag, "_fs"}, frame_start, 0);
        chk({tag, "_addrx"}, addrx, 0);
        chk({tag, "_addry"}, addry, 0);
        chk({tag, "_plane"}, plane, 0);
        chk({tag, "_rgb0"}, rgb0, 0);
        chk({tag, "_rgb1"}, rgb1, 0);
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL timeout %s: condition not reached, expected within bound", nm);
    endtask

    initial begin
        int  n;
        bit  hit;

        // Directed source: r0 = addrx, everything else 0.
        for (int r = 0; r < 2; r++) begin
            for (int x = 0; x < 4; x++) begin
                p0[r][x] = 6'(x);
                p1[r][x] = 6'd0;
            end
        end
        enable = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;

        for (int i = 0; i < NLOG; i++) begin
            @(negedge clk);
            lg_sclk[i]  = sclk;
            lg_latch[i] = latch;
            lg_blank[i] = blank;
            lg_fs[i]    = frame_start;
            lg_r0b0[i]  = rgb0[0];
            lg_addry[i] = addry;
            lg_plane[i] = plane;
        end

        for (int i = 0; i < 4; i++) begin
            chk("lit_sclk_p0", lg_sclk[sclk_p0[i]], 1);
            chk("lit_rgb_p0", lg_r0b0[sclk_p0[i]], bits_p0[i]);
            chk("lit_sclk_p1", lg_sclk[sclk_p1[i]], 1);
            chk("lit_rgb_p1", lg_r0b0[sclk_p1[i]], bits_p1[i]);
        end
        for (int i = 0; i < 7; i++) chk("lit_sclk_low", lg_sclk[sclk_lo[i]], 0);
        chk("lit_fs0", lg_fs[0], 1);
        chk("lit_fs13", lg_fs[13], 0);
        chk("lit_fs28", lg_fs[28], 0);
        chk("lit_fs55", lg_fs[55], 0);
        chk("lit_fs56", lg_fs[56], 1);
        chk("lit_fs112", lg_fs[112], 1);
        chk("lit_latch9", lg_latch[9], 0);
        chk("lit_latch10", lg_latch[10], 1);
        chk("lit_latch23", lg_latch[23], 1);
        chk("lit_blank10", lg_blank[10], 1);
        chk("lit_blank11", lg_blank[11], 0);
        chk("lit_blank12", lg_blank[12], 0);
        chk("lit_blank13", lg_blank[13], 1);
        chk("lit_blank24", lg_blank[24], 0);
        chk("lit_blank27", lg_blank[27], 0);
        chk("lit_blank28", lg_blank[28], 1);
        chk("lit_plane12", lg_plane[12], 0);
        chk("lit_plane13", lg_plane[13], 1);
        chk("lit_plane28", lg_plane[28], 0);
        chk("lit_addry27", lg_addry[27], 0);
        chk("lit_addry28", lg_addry[28], 1);
        chk("lit_addry55", lg_addry[55], 1);
        chk("lit_addry56", lg_addry[56], 0);

        // Drop enable during SHOW of row 1, plane 1.
        hit = 1'b0;
        for (n = 0; n < 200 && !hit; n++) begin
            @(negedge clk);
            hit = (addry == 1'b1) && (plane == 1'b1) && !blank;
        end
        if (!hit) timeout("show_r1p1");
        enable = 1'b0;
        hit = 1'b0;
        for (n = 0; n < 10 && !hit; n++) begin
            @(negedge clk);
            hit = blank;
        end
        if (!hit) timeout("idle_after_drop");
        repeat (4) @(negedge clk);
        chk("idle_blank", blank, 1);
        chk("idle_sclk", sclk, 0);
        enable = 1'b1;
        @(negedge clk);
        chk("restart_fs", frame_start, 1);
        chk("restart_row", addry, 0);

        // Randomised rounds: varied enable patterns, then an async reset mid-SHOW.
        for (int round = 0; round < 6; round++) begin
            rst_n = 1'b0;
            for (int r = 0; r < 2; r++) begin
                for (int x = 0; x < 4; x++) begin
                    p0[r][x] = 6'($urandom);
                    p1[r][x] = 6'($urandom);
                end
            end
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 1500; c++) begin
                @(negedge clk);
                case (round % 3)
                    0:       enable = ($urandom_range(0, 15) != 0);
                    1:       enable = ~enable;
                    default: enable = $urandom_range(0, 1) != 0;
                endcase
            end
            enable = 1'b1;
            hit = 1'b0;
            for (n = 0; n < 300 && !hit; n++) begin
                @(negedge clk);
                hit = !blank;
            end
            if (!hit) timeout("show_for_reset");
            #2;
            rst_n = 1'b0;
            #1;
            chk_reset_vals("async_rst");
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
